// File: rtl/fir_stream_pkg.sv
// Shared types and defaults for the FIR input-stream feeder.
// Holds the sequencer state encoding and a counter-width helper.
package fir_stream_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        COEF  = 2'd2
    } state_t;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_NUM_TAPS   = 4;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_DIV_W      = 8;

    // Bits needed to hold any value 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/fir_stream_source_byte_fifo.sv
// Small synchronous FIFO buffering upstream bytes for the FIR feeder.
// Power-of-two depth so the pointers wrap naturally.
module byte_fifo
    import fir_stream_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic              o_full,
    output logic              o_empty,
    output logic [DATA_W-1:0] o_head
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = cnt_width(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push;
    logic              w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == {CNT_W{1'b0}});
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Storage is left unreset; occupancy is tracked by pointers and count.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fir_stream_source.sv
// Feeds the FIR's x_n/tvalid/set_coeffs inputs from a buffered byte stream:
// paced sample beats in RUN/DRAIN, unpaced coefficient beats in COEF.
module fir_stream_source
    import fir_stream_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int NUM_TAPS   = DEF_NUM_TAPS,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int DIV_W      = DEF_DIV_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              load_coeffs,
    input  logic [DIV_W-1:0]  sample_div,
    output logic [DATA_W-1:0] x_n,
    output logic              s_axis_fir_tvalid,
    output logic              s_set_coeffs,
    output logic              coeff_done,
    output logic              busy
);
    localparam int CNT_W = cnt_width(NUM_TAPS);
    localparam logic [CNT_W-1:0] TAPS_C = CNT_W'(NUM_TAPS);

    state_t            r_state;
    logic [DIV_W-1:0]  r_pacer;
    logic [CNT_W-1:0]  r_acc_cnt;
    logic [CNT_W-1:0]  r_emit_cnt;
    logic [DATA_W-1:0] r_x_n;
    logic              r_tvalid;
    logic              r_set_coeffs;
    logic              r_coeff_done;

    logic              w_full;
    logic              w_empty;
    logic [DATA_W-1:0] w_head;
    logic              w_in_ready;
    logic              w_beat;
    logic              w_push;
    logic              w_last_coef;
    logic              w_pacer_zero;
    logic [DIV_W-1:0]  w_reload;

    byte_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_reset (reset),
        .i_push  (w_push),
        .i_data  (in_data),
        .i_pop   (w_beat),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    assign w_pacer_zero = (r_pacer == {DIV_W{1'b0}});
    // A divider of 0 behaves like 1: back-to-back beats.
    assign w_reload = (sample_div == {DIV_W{1'b0}}) ? {DIV_W{1'b0}}
                                                     : (sample_div - DIV_W'(1));

    // Per-state acceptance and beat decision.
    always_comb begin
        w_in_ready = 1'b0;
        w_beat     = 1'b0;
        case (r_state)
            RUN: begin
                w_in_ready = !w_full;
                w_beat     = !w_empty && w_pacer_zero;
            end
            DRAIN: begin
                w_in_ready = 1'b0;
                w_beat     = !w_empty && w_pacer_zero;
            end
            COEF: begin
                w_in_ready = !w_full && (r_acc_cnt < TAPS_C);
                w_beat     = !w_empty;
            end
            default: begin
                w_in_ready = 1'b0;
                w_beat     = 1'b0;
            end
        endcase
    end

    assign w_push      = in_valid && w_in_ready;
    assign w_last_coef = (r_state == COEF) && w_beat &&
                         (r_emit_cnt == (TAPS_C - CNT_W'(1)));

    // Beat outputs, pacer, counters and sequencing state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= RUN;
            r_pacer      <= {DIV_W{1'b0}};
            r_acc_cnt    <= {CNT_W{1'b0}};
            r_emit_cnt   <= {CNT_W{1'b0}};
            r_x_n        <= {DATA_W{1'b0}};
            r_tvalid     <= 1'b0;
            r_set_coeffs <= 1'b0;
            r_coeff_done <= 1'b0;
        end else begin
            r_tvalid     <= w_beat;
            r_set_coeffs <= w_beat && (r_state == COEF);
            r_coeff_done <= w_last_coef;
            if (w_beat) begin
                r_x_n <= w_head;
            end

            if (w_last_coef) begin
                r_pacer <= {DIV_W{1'b0}};
            end else if (w_beat && (r_state != COEF)) begin
                r_pacer <= w_reload;
            end else if (!w_pacer_zero) begin
                r_pacer <= r_pacer - DIV_W'(1);
            end else begin
                r_pacer <= r_pacer;
            end

            case (r_state)
                RUN: begin
                    if (load_coeffs) begin
                        if (w_empty) begin
                            // A byte pushed on the entry edge is already a coefficient.
                            r_state    <= COEF;
                            r_acc_cnt  <= w_push ? CNT_W'(1) : {CNT_W{1'b0}};
                            r_emit_cnt <= {CNT_W{1'b0}};
                        end else begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_empty && !r_tvalid) begin
                        r_state    <= COEF;
                        r_acc_cnt  <= {CNT_W{1'b0}};
                        r_emit_cnt <= {CNT_W{1'b0}};
                    end
                end
                COEF: begin
                    if (w_push) begin
                        r_acc_cnt <= r_acc_cnt + CNT_W'(1);
                    end
                    if (w_beat) begin
                        r_emit_cnt <= r_emit_cnt + CNT_W'(1);
                    end
                    if (w_last_coef) begin
                        r_state <= RUN;
                    end
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    assign in_ready          = w_in_ready;
    assign x_n               = r_x_n;
    assign s_axis_fir_tvalid = r_tvalid;
    assign s_set_coeffs      = r_set_coeffs;
    assign coeff_done        = r_coeff_done;
    assign busy              = (r_state != RUN) || r_tvalid || !w_empty;

endmodule
